// File: rtl/pipe_sched_pkg.sv
// Shared constants and types for the two-requester pipelined scheduler.
// Optional feature macro used by the top: PIPE_SCHED_FIXED_PRIO_EN.
package pipe_sched_pkg;

    localparam int LATENCY_DEF = 21;
    localparam int WIDTH_DEF   = 32;
    localparam int TAG_W_DEF   = 4;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                 valid;
        req_id_t              id;
        logic [TAG_W_DEF-1:0] tag;
    } track_entry_t;

endpackage

// File: rtl/pipe_sched_track.sv
// LATENCY-deep tracker: shifts {valid, id, tag} alongside the shared datapath.
// All stages clear asynchronously so in-flight ops are dropped on reset.
module pipe_sched_track
    import pipe_sched_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int TAG_W   = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  req_id_t          in_id,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output req_id_t          out_id,
    output logic [TAG_W-1:0] out_tag
);

    logic             stage_vld [LATENCY];
    req_id_t          stage_id  [LATENCY];
    logic [TAG_W-1:0] stage_tag [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_vld[i] <= 1'b0;
                stage_id[i]  <= REQ0;
                stage_tag[i] <= '0;
            end
        end else begin
            stage_vld[0] <= in_valid;
            stage_id[0]  <= in_id;
            stage_tag[0] <= in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                stage_vld[i] <= stage_vld[i-1];
                stage_id[i]  <= stage_id[i-1];
                stage_tag[i] <= stage_tag[i-1];
            end
        end
    end

    assign out_valid = stage_vld[LATENCY-1];
    assign out_id    = stage_id[LATENCY-1];
    assign out_tag   = stage_tag[LATENCY-1];

endmodule

// File: rtl/pipe_sched_rr.sv
// Round-robin scheduler sharing one fixed-latency datapath between two requesters.
// Define PIPE_SCHED_FIXED_PRIO_EN to make requester 0 win every tie instead.
module pipe_sched_rr
    import pipe_sched_pkg::*;
#(
    parameter  int LATENCY = LATENCY_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int TAG_W   = TAG_W_DEF,
    localparam int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [TAG_W-1:0] req0_tag,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             req1_ready,
    input  logic             hold,
    output logic [WIDTH-1:0] pipe_in,
    output logic             pipe_in_valid,
    input  logic [WIDTH-1:0] pipe_out,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic [CNT_W-1:0] inflight,
    output logic             idle
);

    logic             grant0;
    logic             grant1;
    logic             issue;
    req_id_t          grant_id;
    logic [TAG_W-1:0] grant_tag;
    logic             retire;
    req_id_t          retire_id;
    logic [TAG_W-1:0] retire_tag;
    logic             can_grant;

    // Reset is part of the grant qualifier so nothing issues while it is held.
    assign can_grant = GlobalReset & ~hold;

`ifdef PIPE_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant0 = can_grant & req0_valid;
        grant1 = can_grant & req1_valid & ~req0_valid;
    end
`else
    req_id_t last_grant;

    always_comb begin
        grant0 = can_grant & req0_valid & (~req1_valid | (last_grant == REQ1));
        grant1 = can_grant & req1_valid & (~req0_valid | (last_grant == REQ0));
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            last_grant <= REQ1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1 ? REQ1 : REQ0;
        end
    end
`endif

    assign issue      = grant0 | grant1;
    assign grant_id   = grant1 ? REQ1 : REQ0;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        pipe_in   = '0;
        grant_tag = '0;
        if (grant0) begin
            pipe_in   = req0_data;
            grant_tag = req0_tag;
        end else if (grant1) begin
            pipe_in   = req1_data;
            grant_tag = req1_tag;
        end
    end

    assign pipe_in_valid = issue;

    pipe_sched_track #(
        .LATENCY (LATENCY),
        .TAG_W   (TAG_W)
    ) u_track (
        .clk       (clk),
        .rst_n     (GlobalReset),
        .in_valid  (issue),
        .in_id     (grant_id),
        .in_tag    (grant_tag),
        .out_valid (retire),
        .out_id    (retire_id),
        .out_tag   (retire_tag)
    );

    // Retiring op is steered by its recorded id; results are never back-pressured.
    always_comb begin
        rsp0_valid = retire & (retire_id == REQ0);
        rsp1_valid = retire & (retire_id == REQ1);
        rsp0_tag   = rsp0_valid ? retire_tag : '0;
        rsp1_tag   = rsp1_valid ? retire_tag : '0;
    end

    assign rsp0_data = pipe_out;
    assign rsp1_data = pipe_out;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            inflight <= '0;
        end else if (issue && !retire) begin
            inflight <= inflight + 1'b1;
        end else if (!issue && retire) begin
            inflight <= inflight - 1'b1;
        end
    end

    assign idle = (inflight == '0);

endmodule

// File: tb/tb_pipe_sched_rr.sv
// Bench for pipe_sched_rr: grant vector table plus a response scoreboard,
// with a register-chain stand-in for the shared datapath.
module tb_pipe_sched_rr;

    localparam int LAT = 21;
    localparam int W   = 32;
    localparam int TW  = 4;
    localparam int CW  = $clog2(LAT + 1);

`ifdef PIPE_SCHED_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          GlobalReset;
    logic          req0_valid, req1_valid, hold;
    logic [W-1:0]  req0_data, req1_data;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  pipe_in, pipe_out;
    logic          pipe_in_valid;
    logic          rsp0_valid, rsp1_valid;
    logic [W-1:0]  rsp0_data, rsp1_data;
    logic [TW-1:0] rsp0_tag, rsp1_tag;
    logic [CW-1:0] inflight;
    logic          idle;

    always #5 clk = ~clk;

    pipe_sched_rr #(.LATENCY(LAT), .WIDTH(W), .TAG_W(TW)) dut (
        .clk           (clk),
        .GlobalReset   (GlobalReset),
        .req0_valid    (req0_valid),
        .req0_data     (req0_data),
        .req0_tag      (req0_tag),
        .req0_ready    (req0_ready),
        .req1_valid    (req1_valid),
        .req1_data     (req1_data),
        .req1_tag      (req1_tag),
        .req1_ready    (req1_ready),
        .hold          (hold),
        .pipe_in       (pipe_in),
        .pipe_in_valid (pipe_in_valid),
        .pipe_out      (pipe_out),
        .rsp0_valid    (rsp0_valid),
        .rsp0_data     (rsp0_data),
        .rsp0_tag      (rsp0_tag),
        .rsp1_valid    (rsp1_valid),
        .rsp1_data     (rsp1_data),
        .rsp1_tag      (rsp1_tag),
        .inflight      (inflight),
        .idle          (idle)
    );

    // Datapath stand-in: plain register chain, deliberately not reset.
    logic [W-1:0] chain [LAT];
    always @(posedge clk) begin
        chain[0] <= pipe_in;
        for (int i = 1; i < LAT; i++) chain[i] <= chain[i-1];
    end
    assign pipe_out = chain[LAT-1];

    typedef struct {
        int          due;
        logic        id;
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        logic v0;
        logic v1;
        logic hd;
        logic g0;
        logic g1;
    } vec_t;
    vec_t vecs [20];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic v0, input logic v1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                        input logic hd, input logic rs, input logic eg0, input logic eg1);
        int   exp_inf;
        sb_t  e;
        req0_valid  = v0;  req0_data = d0;  req0_tag = t0;
        req1_valid  = v1;  req1_data = d1;  req1_tag = t1;
        hold        = hd;
        GlobalReset = rs;
        @(negedge clk);
        if (!rs) sb.delete();
        check("req0_ready", 32'(req0_ready), 32'(eg0));
        check("req1_ready", 32'(req1_ready), 32'(eg1));
        check("pipe_in_valid", 32'(pipe_in_valid), 32'(eg0 | eg1));
        check("pipe_in", pipe_in, eg0 ? d0 : (eg1 ? d1 : '0));
        exp_inf = sb.size();
        check("inflight", 32'(inflight), 32'(exp_inf));
        check("idle", 32'(idle), 32'(exp_inf == 0));
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rsp0_valid", 32'(rsp0_valid), 32'(e.id == 1'b0));
            check("rsp1_valid", 32'(rsp1_valid), 32'(e.id == 1'b1));
            check("rsp_tag", 32'(e.id ? rsp1_tag : rsp0_tag), 32'(e.tag));
            check("rsp0_data", rsp0_data, e.data);
            check("rsp1_data", rsp1_data, e.data);
        end else begin
            check("rsp0_valid_idle", 32'(rsp0_valid), 32'd0);
            check("rsp1_valid_idle", 32'(rsp1_valid), 32'd0);
        end
        if (!rs) begin
            check("rsp0_tag_rst", 32'(rsp0_tag), 32'd0);
            check("rsp1_tag_rst", 32'(rsp1_tag), 32'd0);
        end
        if (eg0 || eg1) begin
            e.due  = cyc + LAT;
            e.id   = eg1;
            e.tag  = eg0 ? t0 : t1;
            e.data = eg0 ? d0 : d1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n, input logic rs);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, rs, 1'b0, 1'b0);
    endtask

    initial begin
        GlobalReset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; hold = 1'b0;
        req0_data = '0; req1_data = '0; req0_tag = '0; req1_tag = '0;

        // Grant table: contention, hold window, then single-requester rows.
        for (int i = 0; i < 20; i++) begin
            vecs[i].v0 = 1'b1; vecs[i].v1 = 1'b1; vecs[i].hd = 1'b0;
            vecs[i].g0 = 1'b0; vecs[i].g1 = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            vecs[i].g0 = FIXED ? 1'b1 : (i % 2 == 0);
            vecs[i].g1 = FIXED ? 1'b0 : (i % 2 == 1);
        end
        for (int i = 10; i < 15; i++) vecs[i].hd = 1'b1;
        vecs[15].g0 = 1'b1;
        vecs[16].g0 = FIXED;         vecs[16].g1 = !FIXED;
        vecs[17].v0 = 1'b0;          vecs[17].g1 = 1'b1;
        vecs[18].v1 = 1'b0;          vecs[18].g0 = 1'b1;
        vecs[19].v0 = 1'b0;          vecs[19].v1 = 1'b0;

        @(posedge clk);
        #1;

        // Reset held with both requesters valid, then first tie after release.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h1111_0000, 32'h2222_0000, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h1111_0001, 32'h2222_0001, 4'd5, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(LAT + 4, 1'b1);

        // Single op from requester 0.
        step(1'b1, 1'b0, 32'h1234_5678, '0, 4'd3, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(LAT + 4, 1'b1);

        // Fresh reset so the contention table starts from the reset priority.
        idle_steps(2, 1'b0);
        for (int i = 0; i < 20; i++)
            step(vecs[i].v0, vecs[i].v1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i),
                 4'(i), 4'(i), vecs[i].hd, 1'b1, vecs[i].g0, vecs[i].g1);
        idle_steps(LAT + 4, 1'b1);

        // Saturation: back-to-back issue from requester 0, then drain.
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b0, $urandom, '0, 4'(i), '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(LAT + 4, 1'b1);

        // Reset with ops still in flight: their results must never surface.
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 32'hC000_0000 + 32'(i), '0, 4'(i + 8), '0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle_steps(3, 1'b1);
        idle_steps(2, 1'b0);
        idle_steps(LAT, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
